// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Signal bundle between the instruction-fetch stage and its
//                environment: hazard/redirect controls from decode, the
//                instruction-memory request/response port and the IF/ID
//                register with its decoded field slices.
//                master = fetch stage side, slave = decode/memory side.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
  // decode -> fetch controls
  logic        stall;
  logic        pc_select;
  logic [31:0] branch_dir;

  // instruction memory port
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  // IF/ID pipeline register
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  // field slices of the IF/ID instruction
  logic [4:0]  opcode;
  logic [3:0]  Rd;
  logic [3:0]  Ra;
  logic [3:0]  Rb;
  logic [3:0]  Rd2;
  logic [18:0] Imm;

  modport master (
    input  stall, pc_select, branch_dir,
    input  imem_valid, imem_rdata,
    output imem_req, imem_addr,
    output if_id_valid, if_id_pc, if_id_instr,
    output opcode, Rd, Ra, Rb, Rd2, Imm
  );

  modport slave (
    output stall, pc_select, branch_dir,
    output imem_valid, imem_rdata,
    input  imem_req, imem_addr,
    input  if_id_valid, if_id_pc, if_id_instr,
    input  opcode, Rd, Ra, Rb, Rd2, Imm
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage with IF/ID pipeline register.
//                Owns the PC, issues one fetch at a time over a valid
//                handshake, parks one completed instruction in a skid buffer
//                while decode stalls, and applies taken-branch redirects.
//                Optional macro FETCH_BRANCH_FLUSH_EN: when defined, the
//                instruction following a taken branch is discarded (1 bubble);
//                when undefined it executes as a delay slot.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire            clk,
  input  wire            rst,
  fetch_stage_if.master  bus
);

`ifdef FETCH_BRANCH_FLUSH_EN
  localparam logic c_flush_en = 1'b1;
`else
  localparam logic c_flush_en = 1'b0;
`endif

  localparam logic [31:0] c_pc_step = 32'd4;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,   // request outstanding at r_pc
    S_HOLD  = 1'b1    // fetched word parked in r_buf_instr, no request
  } state_t;

  // registered state
  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_redir_pend;
  logic [31:0] r_redir_tgt;
  logic [31:0] r_buf_instr;
  logic        r_if_id_valid;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_instr;

  // next-state values
  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_redir_pend_nxt;
  logic [31:0] w_redir_tgt_nxt;
  logic [31:0] w_buf_instr_nxt;
  logic        w_if_id_valid_nxt;
  logic [31:0] w_if_id_pc_nxt;
  logic [31:0] w_if_id_instr_nxt;

  // decoded events
  logic        w_accept;
  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  // A response counts only while a request is actually outstanding.
  assign w_accept   = (r_state == S_FETCH) && bus.imem_valid;

  // Branches are taken only from a real, non-stalled IF/ID instruction. A
  // redirect that is already pending blocks a second one (IF/ID is a bubble
  // then anyway, so this only guards against a misbehaving decode).
  assign w_redir    = bus.pc_select && !bus.stall && r_if_id_valid && !r_redir_pend;
  assign w_target   = r_if_id_pc + bus.branch_dir;
  assign w_pc_plus4 = r_pc + c_pc_step;

  // Next-state and IF/ID update for every combination of response, stall
  // and redirect; everything holds unless a branch below says otherwise.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_redir_pend_nxt  = r_redir_pend;
    w_redir_tgt_nxt   = r_redir_tgt;
    w_buf_instr_nxt   = r_buf_instr;
    w_if_id_valid_nxt = r_if_id_valid;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_instr_nxt = r_if_id_instr;

    case (r_state)
      S_FETCH: begin
        if (w_accept && !bus.stall) begin
          if (w_redir) begin
            // The word just fetched sits at if_id_pc+4: delay slot or flush.
            w_pc_nxt = w_target;
            if (c_flush_en) begin
              w_if_id_valid_nxt = 1'b0;
              w_if_id_instr_nxt = 32'h0;
            end else begin
              w_if_id_valid_nxt = 1'b1;
              w_if_id_pc_nxt    = r_pc;
              w_if_id_instr_nxt = bus.imem_rdata;
            end
          end else if (r_redir_pend) begin
            // The fetch that was in flight when the branch was taken has
            // now returned; resume at the saved target.
            w_pc_nxt         = r_redir_tgt;
            w_redir_pend_nxt = 1'b0;
            if (c_flush_en) begin
              w_if_id_valid_nxt = 1'b0;
              w_if_id_instr_nxt = 32'h0;
            end else begin
              w_if_id_valid_nxt = 1'b1;
              w_if_id_pc_nxt    = r_pc;
              w_if_id_instr_nxt = bus.imem_rdata;
            end
          end else begin
            w_pc_nxt          = w_pc_plus4;
            w_if_id_valid_nxt = 1'b1;
            w_if_id_pc_nxt    = r_pc;
            w_if_id_instr_nxt = bus.imem_rdata;
          end
        end else if (w_accept) begin
          // Decode is stalled: IF/ID holds, the new word must be parked.
          if (c_flush_en && r_redir_pend) begin
            // Word is the squashed fall-through; drop it and refetch.
            w_pc_nxt         = r_redir_tgt;
            w_redir_pend_nxt = 1'b0;
          end else begin
            w_buf_instr_nxt = bus.imem_rdata;
            w_state_nxt     = S_HOLD;
          end
        end else if (!bus.stall) begin
          // Still waiting on memory: decode sees a bubble. A branch taken
          // now must wait for the outstanding fetch before moving the PC.
          w_if_id_valid_nxt = 1'b0;
          w_if_id_instr_nxt = 32'h0;
          if (w_redir) begin
            w_redir_pend_nxt = 1'b1;
            w_redir_tgt_nxt  = w_target;
          end
        end
      end

      S_HOLD: begin
        if (!bus.stall) begin
          w_state_nxt = S_FETCH;
          if (w_redir) begin
            // Buffered word is at if_id_pc+4: delay slot or flush.
            w_pc_nxt = w_target;
            if (c_flush_en) begin
              w_if_id_valid_nxt = 1'b0;
              w_if_id_instr_nxt = 32'h0;
            end else begin
              w_if_id_valid_nxt = 1'b1;
              w_if_id_pc_nxt    = r_pc;
              w_if_id_instr_nxt = r_buf_instr;
            end
          end else begin
            // The buffered word always lives at r_pc since the PC does not
            // advance on entry to HOLD. A pending redirect here can only be
            // a delay slot that got parked behind a stall.
            w_pc_nxt          = r_redir_pend ? r_redir_tgt : w_pc_plus4;
            w_redir_pend_nxt  = 1'b0;
            w_if_id_valid_nxt = 1'b1;
            w_if_id_pc_nxt    = r_pc;
            w_if_id_instr_nxt = r_buf_instr;
          end
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // State, PC, redirect and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_redir_pend  <= 1'b0;
      r_redir_tgt   <= 32'h0;
      r_buf_instr   <= 32'h0;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_redir_pend  <= w_redir_pend_nxt;
      r_redir_tgt   <= w_redir_tgt_nxt;
      r_buf_instr   <= w_buf_instr_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_instr <= w_if_id_instr_nxt;
    end
  end

  // Request is suppressed in the reset cycle so memory never sees a stale PC.
  assign bus.imem_req    = (r_state == S_FETCH) && !rst;
  assign bus.imem_addr   = r_pc;

  assign bus.if_id_valid = r_if_id_valid;
  assign bus.if_id_pc    = r_if_id_pc;
  assign bus.if_id_instr = r_if_id_instr;

  assign bus.opcode      = r_if_id_instr[31:27];
  assign bus.Rd          = r_if_id_instr[26:23];
  assign bus.Ra          = r_if_id_instr[22:19];
  assign bus.Rb          = r_if_id_instr[18:15];
  assign bus.Rd2         = r_if_id_instr[14:11];
  assign bus.Imm         = r_if_id_instr[18:0];

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register feeding the decode stage. It owns the program counter, fetches 32-bit instructions over a valid-handshake memory port and buffers one instruction when decode stalls. It applies taken-branch redirects from decode (`pc_select`, `branch_dir`) and presents the registered instruction split into the register and immediate fields that decode consumes.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset.

Ports:
- `clk`  in  1  clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard hold; IF/ID keeps its contents.
- `pc_select`  in  1  decode: the IF/ID instruction is a taken branch.
- `branch_dir`  in  32  decode: byte offset, already sign-extended and shifted.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch byte address.
- `imem_valid`  in  1  `imem_rdata` valid; the fetch completes this cycle.
- `imem_rdata`  in  32  instruction word.
- `if_id_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `if_id_pc`  out  32  address of the IF/ID instruction.
- `if_id_instr`  out  32  IF/ID instruction; 32'h0 when it is a bubble.
- `opcode`  out  5  `if_id_instr[31:27]`.
- `Rd`  out  4  `[26:23]`.
- `Ra`  out  4  `[22:19]`.
- `Rb`  out  4  `[18:15]`.
- `Rd2`  out  4  `[14:11]`.
- `Imm`  out  19  `[18:0]`.

## Operation
- FSM states:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - HOLD: `imem_req`=0; one completed instruction is in the skid buffer.
- Auxiliary registers:
  - `redir_pend` flag and `redir_tgt[31:0]`.
- A response is accepted only in FETCH when `imem_valid`=1. `imem_valid` is ignored in HOLD and during `rst`.
- Redirects are accepted only when `pc_select`=1, `stall`=0 and `if_id_valid`=1. Target = `if_id_pc + branch_dir`, mod 2^32.
- `imem_addr` stays stable while `imem_req`=1 and no response has been accepted. A pending fetch is never changed or aborted.
- FETCH, response accepted, `stall`=0, no redirect:
  - IF/ID loads {1, `pc`, `imem_rdata`}.
  - `pc` becomes `redir_pend ? redir_tgt : pc+4`, and `redir_pend` clears.
  - Exception: with flush configured and `redir_pend`=1, the response is discarded instead of loaded and IF/ID becomes a bubble.
- FETCH, response accepted, `stall`=1:
  - The response goes into the buffer, the state moves to HOLD and `pc` is unchanged.
  - With flush configured and `redir_pend`=1, the response is discarded instead. `pc` becomes `redir_tgt`, `redir_pend` clears and the state stays FETCH.
- FETCH, no response, `stall`=0: IF/ID becomes a bubble.
- HOLD with `stall`=1: everything holds.
- HOLD with `stall`=0:
  - The buffer moves to IF/ID, `pc` becomes `pc+4` and the state returns to FETCH.
  - A redirect accepted in this cycle is handled by the redirect rules below.
- Redirect accepted while a response is accepted in the same cycle, or in HOLD: `pc` becomes the target, and the fetched or buffered instruction at `if_id_pc+4` is handled per Configuration.
- Redirect accepted with no response:
  - `redir_pend` sets and `redir_tgt` latches the target.
  - IF/ID becomes a bubble.
  - The outstanding response is handled per Configuration, then `pc` becomes `redir_tgt`.
- A redirect cannot arrive while `redir_pend` is set, because IF/ID is a bubble then. If it does, it is ignored.
- When `stall`=1, `pc_select` is ignored. Decode re-asserts it because IF/ID holds.
- Field outputs are combinational slices of `if_id_instr`.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state FETCH, `redir_pend`=0.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=0, buffer cleared.
  - `imem_req`=0 during the `rst` cycle and 1 from the first cycle after.
- Reset mid-operation: an in-flight fetch is abandoned, and the first fetch after `rst` is `RESET_PC`.
- Memory latency:
  - Zero-wait memory (`imem_valid` in the same cycle as the request): one instruction per cycle.
  - Each added wait cycle inserts one IF/ID bubble.
- IF/ID outputs change only on clock edges, one cycle after the accepted response.
- Branch penalty with zero-wait memory:
  - Flush configured: 1 bubble.
  - Flush not configured: 0 bubbles (the delay-slot instruction is executed).

## Configuration
- `FETCH_BRANCH_FLUSH_EN` defined:
  - The instruction at `if_id_pc+4`, whether fetched in the redirect cycle, buffered, or still outstanding, is discarded.
  - IF/ID becomes a bubble. The next valid instruction is at the target.
- `FETCH_BRANCH_FLUSH_EN` undefined:
  - One architectural delay slot. The instruction at `if_id_pc+4` is delivered to IF/ID normally, respecting `stall`, then fetch continues at the target.

## Test plan
- Reset with zero-wait memory where `imem_rdata`=addr^32'hA5A5_0000:
  - `imem_addr` runs 0, 4, 8 on consecutive cycles.
  - `if_id_valid`=1 from cycle 2, and `if_id_pc` trails `imem_addr` by 1.
- Instruction 32'h0C9C_5800 in IF/ID → opcode=1, Rd=9, Ra=3, Rb=8, Rd2=11, Imm=19'h45800.
- `stall` high for 3 cycles during streaming:
  - IF/ID frozen, HOLD entered, `imem_req`=0.
  - On release, the buffered instruction enters IF/ID; no instruction is lost or duplicated.
- Branch at `if_id_pc`=0x10 with `branch_dir`=0x40 and zero-wait memory:
  - FLUSH_EN: bubble, then `if_id_pc`=0x50.
  - No FLUSH_EN: `if_id_pc`=0x14, then 0x50.
- Branch while the fetch of 0x14 waits 2 cycles: `imem_addr` holds 0x14 until valid, then 0x50.
  - FLUSH_EN: 0x14 is never valid in IF/ID.
  - No FLUSH_EN: 0x14 is delivered.
- `rst` asserted while a fetch is waiting: outputs return to reset values, and the next `imem_addr` is `RESET_PC`.
